// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer and its LFSR.
package dice_pkg;

  typedef logic [2:0] face_t;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    HOLD
  } roll_state_e;

  localparam face_t FACE_BLANK = 3'd0;

  // Right-shift Galois toggle mask for x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/dice_roll_ctrl_if.sv
// Button/clear inputs and face/status outputs of the dice roll sequencer.
interface dice_roll_ctrl_if;
  import dice_pkg::*;

  logic  roll_btn;
  logic  clear;
  face_t face;
  logic  rolling;
  logic  done;

  modport master (
    output roll_btn,
    output clear,
    input  face,
    input  rolling,
    input  done
  );

  modport slave (
    input  roll_btn,
    input  clear,
    output face,
    output rolling,
    output done
  );

endinterface

// File: rtl/dice_lfsr.sv
// Free-running 8-bit Galois LFSR; advances on every clock regardless of the sequencer state.
module dice_lfsr
  import dice_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic [7:0] w_q_next;

  always_comb begin
    w_q_next = {1'b0, r_q[7:1]};
    if (r_q[0]) begin
      w_q_next = w_q_next ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= LFSR_SEED;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll animation sequencer: a button edge starts a run of face changes with growing dwell,
// then the last face is held and a one-cycle done pulse marks the commit.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int         TICK_DIV   = 4_000_000,
  parameter int         ROLL_STEPS = 12,
  parameter int         MAX_FACE   = 6,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  dice_roll_ctrl_if.slave bus
);

  localparam int                DW          = $clog2(TICK_DIV * ROLL_STEPS) + 1;
  localparam int                SW          = 5;
  localparam face_t             MAXF        = 3'(MAX_FACE);
  localparam logic [SW-1:0]     LAST_STEP   = SW'(ROLL_STEPS - 1);
  localparam logic [DW-1:0]     FIRST_DWELL = DW'(TICK_DIV - 1);

  roll_state_e   r_state, w_state_next;
  face_t         r_face, w_face_next;
  logic          r_rolling, w_rolling_next;
  logic          r_done, w_done_next;
  logic          r_btn_q;
  logic [SW-1:0] r_step, w_step_next;
  logic [DW-1:0] r_dwell, w_dwell_next;
  logic [DW-1:0] w_dwell_reload;
  logic [7:0]    w_lfsr;
  logic          w_start;
  face_t         w_cand_raw, w_cand;
  logic          w_unused_lfsr;

  dice_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (w_lfsr)
  );

  assign w_unused_lfsr  = ^w_lfsr[7:3];
  assign w_start        = bus.roll_btn & ~r_btn_q;
  assign w_cand_raw     = (w_lfsr[2:0] % MAXF) + 3'd1;
  // Dwell for the step being entered: step_new = r_step + 1, held TICK_DIV*(step_new+1) cycles.
  assign w_dwell_reload = DW'(TICK_DIV * (int'(r_step) + 2) - 1);

  // Bump a repeated candidate so every step is visibly different from the previous face.
  always_comb begin
    w_cand = w_cand_raw;
    if ((MAX_FACE > 1) && (w_cand_raw == r_face)) begin
      w_cand = (r_face == MAXF) ? 3'd1 : r_face + 3'd1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_face_next    = r_face;
    w_rolling_next = r_rolling;
    w_done_next    = 1'b0;
    w_step_next    = r_step;
    w_dwell_next   = r_dwell;

    if (bus.clear) begin
      w_state_next   = IDLE;
      w_face_next    = FACE_BLANK;
      w_rolling_next = 1'b0;
      w_step_next    = '0;
      w_dwell_next   = '0;
    end else begin
      unique case (r_state)
        IDLE, HOLD: begin
          if (r_state == IDLE) begin
            w_face_next = FACE_BLANK;
          end
          if (w_start) begin
            w_state_next   = ROLL;
            w_face_next    = w_cand;
            w_step_next    = '0;
            w_dwell_next   = FIRST_DWELL;
            w_rolling_next = 1'b1;
          end
        end
        ROLL: begin
          if (r_dwell != '0) begin
            w_dwell_next = r_dwell - 1'b1;
          end else if (r_step == LAST_STEP) begin
            w_state_next   = HOLD;
            w_rolling_next = 1'b0;
            w_done_next    = 1'b1;
          end else begin
            w_step_next  = r_step + 1'b1;
            w_face_next  = w_cand;
            w_dwell_next = w_dwell_reload;
          end
        end
        default: begin
          w_state_next   = IDLE;
          w_face_next    = FACE_BLANK;
          w_rolling_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_face    <= FACE_BLANK;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
      r_btn_q   <= 1'b0;
      r_step    <= '0;
      r_dwell   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_face    <= w_face_next;
      r_rolling <= w_rolling_next;
      r_done    <= w_done_next;
      r_btn_q   <= bus.roll_btn;
      r_step    <= w_step_next;
      r_dwell   <= w_dwell_next;
    end
  end

  assign bus.face    = r_face;
  assign bus.rolling = r_rolling;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Randomized bench for dice_roll_ctrl: each roll's face schedule is predicted from the
// LFSR sequence and the dwell-per-step arithmetic, then compared cycle by cycle.
module tb_dice_roll_ctrl;
  import dice_pkg::*;

  localparam int T  = 2;
  localparam int S  = 3;
  localparam int MF = 6;
  localparam int L  = T * S * (S + 1) / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dice_roll_ctrl_if bus();

  dice_roll_ctrl #(
    .TICK_DIV  (T),
    .ROLL_STEPS(S),
    .MAX_FACE  (MF),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc;
  logic [7:0] seq [0:16383];
  logic [2:0] m_face;
  int         seen [1:7];
  bit         stopped;

  // Number of clock edges since reset release; edge n sees LFSR value seq[n].
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pick(input logic [7:0] l, input logic [2:0] prev);
    int c;
    c = (int'(l[2:0]) % MF) + 1;
    if (c == int'(prev) && MF > 1) c = (int'(prev) == MF) ? 1 : int'(prev) + 1;
    return 3'(c);
  endfunction

  // mode 0: single press, 1: held through roll, 2: extra press mid-roll, 3: clear on final step
  task automatic run_roll(input int mode, input int stop_j, output bit stp);
    int         e;
    int         kc;
    int         off [0:30];
    logic [2:0] f   [0:30];
    logic [2:0] pf;
    logic [2:0] prev_obs;
    bit         clr;
    e  = cyc;
    pf = m_face;
    for (int k = 0; k < S; k++) begin
      off[k] = T * k * (k + 1) / 2;
      f[k]   = pick(seq[e + off[k]], pf);
      pf     = f[k];
    end
    prev_obs     = bus.face;
    stp          = 1'b0;
    bus.roll_btn = 1'b1;
    tick();
    for (int j = 0; j <= L + 1; j++) begin
      clr = (mode == 3) && (j >= L);
      kc  = 0;
      for (int k = 1; k < S; k++) if (off[k] <= j) kc = k;
      chk("face", bus.face, clr ? 32'd0 : 32'(f[kc]));
      chk("rolling", bus.rolling, (j < L) ? 32'd1 : 32'd0);
      chk("done", bus.done, (!clr && j == L) ? 32'd1 : 32'd0);
      if (!clr && j < L && j == off[kc]) begin
        chk("face_range", (bus.face >= 3'd1 && bus.face <= 3'(MF)), 1);
        chk("step_change", (bus.face != prev_obs), 1);
        prev_obs = bus.face;
      end
      if (j == stop_j) begin
        stp = 1'b1;
        return;
      end
      if (j == L + 1) break;
      bus.roll_btn = (mode == 1) || (mode == 2 && j == 3);
      bus.clear    = (mode == 3 && j == L - 1);
      tick();
    end
    bus.roll_btn = 1'b0;
    bus.clear    = 1'b0;
    tick();
    chk("no_retrigger", bus.rolling, 0);
    chk("hold_face", bus.face, (mode == 3) ? 32'd0 : 32'(f[S-1]));
    if (mode == 3) begin
      m_face = FACE_BLANK;
    end else begin
      m_face = f[S-1];
      seen[f[S-1]]++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.roll_btn = 1'b0;
    bus.clear    = 1'b0;
    m_face       = FACE_BLANK;
    for (int v = 1; v <= 7; v++) seen[v] = 0;
    seq[0] = 8'hA5;
    for (int i = 1; i < 16384; i++)
      seq[i] = seq[i-1][0] ? ((seq[i-1] >> 1) ^ 8'hB8) : (seq[i-1] >> 1);

    // Reset and quiet idle
    #1 rst_n = 1'b0;
    #1;
    chk("rst_face", bus.face, 0);
    chk("rst_rolling", bus.rolling, 0);
    chk("rst_done", bus.done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_face", bus.face, 0);
      chk("idle_rolling", bus.rolling, 0);
      chk("idle_done", bus.done, 0);
    end

    // Basic, held, mid-roll press, press from HOLD
    run_roll(0, -1, stopped);
    run_roll(1, -1, stopped);
    run_roll(2, -1, stopped);
    run_roll(0, -1, stopped);

    // Random rolls with random idle gaps
    for (int r = 0; r < 500; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_face", bus.face, m_face);
        chk("gap_rolling", bus.rolling, 0);
      end
      run_roll(int'($urandom_range(0, 2)), -1, stopped);
    end
    for (int v = 1; v <= MF; v++) chk($sformatf("final_seen_%0d", v), (seen[v] > 0), 1);

    // clear together with start while IDLE
    bus.clear = 1'b1;
    tick();
    chk("clear_face", bus.face, 0);
    bus.clear = 1'b0;
    tick();
    m_face       = FACE_BLANK;
    bus.clear    = 1'b1;
    bus.roll_btn = 1'b1;
    tick();
    chk("clr_start_face", bus.face, 0);
    chk("clr_start_rolling", bus.rolling, 0);
    bus.clear = 1'b0;
    tick();
    chk("held_btn_rolling", bus.rolling, 0);
    bus.roll_btn = 1'b0;
    tick();
    chk("held_btn_face", bus.face, 0);

    // clear on the final-step cycle
    run_roll(3, -1, stopped);

    // async reset at step 1, then replay of the first roll's schedule
    run_roll(0, T, stopped);
    chk("stopped_at_step1", stopped, 1);
    rst_n = 1'b0;
    #1;
    chk("async_face", bus.face, 0);
    chk("async_rolling", bus.rolling, 0);
    chk("async_done", bus.done, 0);
    tick();
    tick();
    rst_n        = 1'b1;
    bus.roll_btn = 1'b0;
    m_face       = FACE_BLANK;
    repeat (100) tick();
    run_roll(0, -1, stopped);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
Sequencer for the nine-segment dice decoder. A button press starts a "roll" animation: the face value changes repeatedly, with each step held longer than the previous one. The face then settles on a pseudo-random final value and holds it. The face output drives the decoder's 3-bit select, where 0 means blank and 1..7 are pip counts.

Parameters:
TICK_DIV, 4_000_000, base dwell in clk cycles; step k (0-based) is held TICK_DIV*(k+1) cycles
ROLL_STEPS, 12, number of face changes per roll (legal range 1..31)
MAX_FACE, 6, highest face produced (legal range 1..7)
LFSR_SEED, 8'hA5, nonzero reset value of the internal LFSR

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
roll_btn  in  1  debounced, synchronised roll button; level input, rising edge starts a roll
clear  in  1  synchronous request to blank the display and return to IDLE
face  out  3  decoder select: 0 = blank, 1..MAX_FACE = current face
rolling  out  1  high while the animation runs
done  out  1  single-cycle pulse when the final face is committed

Behaviour:
- Reset (async, rst_n=0): state=IDLE, face=0, rolling=0, done=0, btn_q=0, lfsr=LFSR_SEED, step=0, dwell=0.
- Edge detect: btn_q registers roll_btn each cycle. start = roll_btn & ~btn_q.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, advances every cycle regardless of state.
- Candidate face: cand = (lfsr[2:0] mod MAX_FACE) + 1, using the lfsr value in the loading cycle.
  - If cand == face and MAX_FACE > 1: use (face == MAX_FACE) ? 1 : face+1. This guarantees a visible change each step.
- States: IDLE, ROLL, HOLD.
  - IDLE: face=0. On start, go to ROLL next cycle and, on that same edge, load face=cand, step=0, dwell=TICK_DIV-1, rolling=1.
  - ROLL: dwell decrements every cycle.
    - dwell==0 and step<ROLL_STEPS-1: step++, face=cand, dwell=TICK_DIV*(step_new+1)-1.
    - dwell==0 and step==ROLL_STEPS-1: go to HOLD, rolling=0, done=1 for one cycle, face unchanged.
  - HOLD: face held. On start, begin a new roll exactly as from IDLE (face overwritten by cand, not blanked).
- Latency: rolling is high for exactly TICK_DIV*ROLL_STEPS*(ROLL_STEPS+1)/2 cycles. Face changes exactly ROLL_STEPS times, counting the load on start.
- start during ROLL is ignored. A held button does not retrigger; it must be released and pressed again.
- clear in any state: next cycle state=IDLE, face=0, rolling=0, done=0. clear wins over a simultaneous start and over a simultaneous final step (no done pulse).
- rst_n asserted mid-roll: immediate return to reset values; no done pulse.
- The dwell counter is sized $clog2(TICK_DIV*ROLL_STEPS)+1 bits. No overflow is permitted at the legal parameter limits.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package dice_pkg holds:
  - typedef face_t (logic [2:0])
  - enum roll_state_e {IDLE, ROLL, HOLD}
  - constant FACE_BLANK = 3'd0
  - LFSR tap constant
- Sub-module dice_lfsr: 8-bit free-running Galois LFSR with seed parameter, ports clk, rst_n, q[7:0].
- Face-candidate selection stays inline in dice_roll_ctrl.

Test Plan:
- Reset: hold rst_n=0, then release -> face=0, rolling=0, done=0, and they stay so for 100 cycles with roll_btn=0.
- Basic roll (TICK_DIV=2, ROLL_STEPS=3, MAX_FACE=6): pulse roll_btn at cycle N.
  - rolling=1 from N+1 through N+12; face changes at N+1, N+3, N+7.
  - done=1 only at N+13; face in 1..6 and matches the bench LFSR model seeded 8'hA5.
- Retrigger rules: hold roll_btn high through a whole roll -> exactly one roll. Press again mid-roll -> ignored (rolling length still 12). Press in HOLD -> new roll starts, face never returns to 0.
- Face legality: MAX_FACE=6, 500 rolls -> face never 0 or 7 while rolling/HOLD, consecutive step values always differ, every value 1..6 occurs as a final face.
- Clear collisions: clear together with start in IDLE -> stays IDLE, face=0. clear on the final-step cycle -> IDLE, face=0, no done pulse.
- Async reset mid-roll: drop rst_n at step 1 -> outputs return to 0 immediately without waiting for a clk edge. After release the LFSR restarts from 8'hA5 and the next roll reproduces the first roll's face sequence.
